// File: rtl/voice_alloc_if.sv
// voice_alloc_if: request/response bundle between the command decoder and the
// voice allocator.
//   slave  modport : allocator side (takes requests, drives status/voice state)
//   master modport : decoder side
//   note_on_i / note_off_i / note_i        : request and note number
//   ready_o / done_o / hit_o / idx_o       : handshake and result
//   voice_mask_o / voice_note_o / count_o  : per-voice state for the oscillators
interface voice_alloc_if #(
  parameter int OSC_VOICES = 7,
  parameter int NOTE_W     = 7
);
  localparam int IDX_W  = (OSC_VOICES > 1) ? $clog2(OSC_VOICES) : 1;
  localparam int CNTLEN = $clog2(OSC_VOICES + 1);

  logic                         note_on_i;
  logic                         note_off_i;
  logic [NOTE_W-1:0]            note_i;
  logic                         ready_o;
  logic                         done_o;
  logic                         hit_o;
  logic [IDX_W-1:0]             idx_o;
  logic [OSC_VOICES-1:0]        voice_mask_o;
  logic [OSC_VOICES*NOTE_W-1:0] voice_note_o;
  logic [CNTLEN-1:0]            count_o;

  modport slave (
    input  note_on_i, note_off_i, note_i,
    output ready_o, done_o, hit_o, idx_o, voice_mask_o, voice_note_o, count_o
  );
  modport master (
    output note_on_i, note_off_i, note_i,
    input  ready_o, done_o, hit_o, idx_o, voice_mask_o, voice_note_o, count_o
  );
endinterface

// File: rtl/voice_alloc.sv
// voice_alloc: turns serialized note-on/note-off requests into a per-voice
// active mask plus stored note numbers. Voices are searched one index per
// clock. Active-voice count comes from an internal bitcount instance.
//   clk_i  : system clock
//   nrst_i : async active-low reset
//   bus    : voice_alloc_if.slave (request handshake, result, voice state)
// Optional build macro VOICE_STEAL_EN: a note_on while all voices are busy
// re-uses the voice at a round-robin steal pointer instead of being dropped.

module voice_alloc_bitcount #(
  parameter int W  = 7,
  parameter int CW = 3
) (
  input  logic [W-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(bits_i[i]);
  end
endmodule

module voice_alloc #(
  parameter int OSC_VOICES = 7,
  parameter int NOTE_W     = 7
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  voice_alloc_if.slave  bus
);
  localparam int IDX_W  = (OSC_VOICES > 1) ? $clog2(OSC_VOICES) : 1;
  localparam int CNTLEN = $clog2(OSC_VOICES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                               state_q;
  logic                                 ready_q, done_q, hit_q;
  logic                                 op_off_q, full_q;
  logic [NOTE_W-1:0]                    note_q;
  logic [IDX_W-1:0]                     ptr_q, idx_q;
  logic [OSC_VOICES-1:0]                mask_q;
  logic [OSC_VOICES-1:0][NOTE_W-1:0]    notes_q;
  logic [CNTLEN-1:0]                    count;
  logic                                 last_idx, off_match;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]                     steal_q;
`endif

  voice_alloc_bitcount #(.W(OSC_VOICES), .CW(CNTLEN)) u_bitcount (
    .bits_i (mask_q),
    .cnt_o  (count)
  );

  assign last_idx  = (ptr_q == IDX_W'(OSC_VOICES - 1));
  assign off_match = mask_q[ptr_q] && (notes_q[ptr_q] == note_q);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      op_off_q <= 1'b0;
      full_q   <= 1'b0;
      note_q   <= '0;
      ptr_q    <= '0;
      mask_q   <= '0;
      notes_q  <= '0;
`ifdef VOICE_STEAL_EN
      steal_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.note_on_i || bus.note_off_i) begin
            // off has priority; a simultaneous on stays pending at the caller
            op_off_q <= bus.note_off_i;
            note_q   <= bus.note_i;
            full_q   <= !bus.note_off_i && (count == CNTLEN'(OSC_VOICES));
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (full_q) begin
            // full note_on: one decision cycle, no index search
`ifdef VOICE_STEAL_EN
            notes_q[steal_q] <= note_q;
            idx_q            <= steal_q;
            hit_q            <= 1'b1;
            steal_q          <= (steal_q == IDX_W'(OSC_VOICES - 1)) ? '0
                                                                    : steal_q + IDX_W'(1);
`else
            hit_q            <= 1'b0;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (op_off_q) begin
            if (off_match) begin
              mask_q[ptr_q] <= 1'b0;
              idx_q         <= ptr_q;
              hit_q         <= 1'b1;
              done_q        <= 1'b1;
              state_q       <= DONE;
            end else if (last_idx) begin
              hit_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end else begin
            if (!mask_q[ptr_q]) begin
              mask_q[ptr_q]  <= 1'b1;
              notes_q[ptr_q] <= note_q;
              idx_q          <= ptr_q;
              hit_q          <= 1'b1;
              done_q         <= 1'b1;
              state_q        <= DONE;
            end else if (last_idx) begin
              // unreachable while mask only changes here; kept as a safe exit
              hit_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.done_o       = done_q;
  assign bus.hit_o        = hit_q;
  assign bus.idx_o        = idx_q;
  assign bus.voice_mask_o = mask_q;
  assign bus.voice_note_o = notes_q;
  assign bus.count_o      = count;
endmodule

// File: tb/tb_voice_alloc.sv
module tb_voice_alloc;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   nchk = 0, npass = 0, ndone = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  voice_alloc_if #(.OSC_VOICES(7), .NOTE_W(7)) bus ();
  voice_alloc #(.OSC_VOICES(7), .NOTE_W(7)) dut (
    .clk_i  (clk),
    .nrst_i (nrst),
    .bus    (bus)
  );

  typedef struct {
    logic       on, off;
    logic [6:0] note;
    logic       hit;
    int         idx;
    int         lat;   // 0 = latency not checked
    logic [6:0] mask;
    int         nk;    // voice whose note is checked, -1 = none
    int         nv;
  } vec_t;

  typedef struct {
    logic       hit;
    int         idx;
    int         lat;
    int         acc;
    logic [6:0] mask;
    int         nk;
    int         nv;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];

  task automatic chk(input string nm, input int act, input int expv);
    nchk++;
    if (act != expv) $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    else npass++;
  endtask

  // scoreboard: every done_o pops the oldest expected result
  always @(negedge clk) begin
    if (nrst && bus.done_o) begin
      exp_t e;
      ndone++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("hit", int'(bus.hit_o), int'(e.hit));
        chk("idx", int'(bus.idx_o), e.idx);
        chk("mask", int'(bus.voice_mask_o), int'(e.mask));
        chk("count", int'(bus.count_o), $countones(e.mask));
        if (e.lat > 0) chk("latency", cyc - e.acc, e.lat);
        if (e.nk >= 0) chk("voice_note", int'(bus.voice_note_o[e.nk*7 +: 7]), e.nv);
      end
    end
  end

  function automatic exp_t mk(input vec_t v);
    exp_t e;
    e.hit = v.hit; e.idx = v.idx; e.lat = v.lat; e.acc = 0;
    e.mask = v.mask; e.nk = v.nk; e.nv = v.nv;
    return e;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!bus.ready_o && w < 50) begin @(negedge clk); #1; w++; end
    if (!bus.ready_o) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    int w = 0;
    while (ndone < target && w < 40) begin @(negedge clk); #1; w++; end
    if (ndone < target) chk("done_timeout", ndone, target);
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int d0;
    wait_ready();
    e = mk(v);
    e.acc = cyc;
    sb.push_back(e);
    d0 = ndone;
    bus.note_on_i = v.on; bus.note_off_i = v.off; bus.note_i = v.note;
    @(negedge clk); #1;
    bus.note_on_i = 1'b0; bus.note_off_i = 1'b0;
    wait_done(d0 + 1);
  endtask

  initial begin
    vec_t v;
    int d0;
    bus.note_on_i = 1'b0; bus.note_off_i = 1'b0; bus.note_i = '0;

    //        on off note hit idx lat mask    nk nv
    vt[0]  = '{1, 0, 60, 1, 0, 2, 7'h01,  0, 60};
    vt[1]  = '{1, 0, 64, 1, 1, 3, 7'h03,  1, 64};
    vt[2]  = '{1, 0, 67, 1, 2, 4, 7'h07,  2, 67};
    vt[3]  = '{0, 1, 64, 1, 1, 3, 7'h05, -1,  0};
    vt[4]  = '{1, 0, 72, 1, 1, 3, 7'h07,  1, 72};
    vt[5]  = '{0, 1, 50, 0, 1, 8, 7'h07, -1,  0};
    vt[6]  = '{1, 0, 70, 1, 3, 5, 7'h0F,  3, 70};
    vt[7]  = '{1, 0, 71, 1, 4, 6, 7'h1F,  4, 71};
    vt[8]  = '{1, 0, 73, 1, 5, 7, 7'h3F,  5, 73};
    vt[9]  = '{1, 0, 74, 1, 6, 8, 7'h7F,  6, 74};
`ifdef VOICE_STEAL_EN
    vt[10] = '{1, 0, 80, 1, 0, 2, 7'h7F,  0, 80};
    vt[11] = '{1, 0, 81, 1, 1, 2, 7'h7F,  1, 81};
    vt[12] = '{0, 1, 80, 1, 0, 2, 7'h7E, -1,  0};
`else
    vt[10] = '{1, 0, 80, 0, 6, 2, 7'h7F,  0, 60};
    vt[11] = '{1, 0, 81, 0, 6, 2, 7'h7F,  1, 72};
    vt[12] = '{0, 1, 80, 0, 6, 8, 7'h7F, -1,  0};
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", int'(bus.ready_o), 1);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_hit", int'(bus.hit_o), 0);
    chk("rst_idx", int'(bus.idx_o), 0);
    chk("rst_mask", int'(bus.voice_mask_o), 0);
    chk("rst_count", int'(bus.count_o), 0);
    nrst = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 6; i++) send(vt[i]);

    // on+off together: off (67 at voice 2) served first, held on re-allocates voice 2
    wait_ready();
    sb.push_back('{1'b1, 2, 4, cyc, 7'h03, -1, 0});
    sb.push_back('{1'b1, 2, 4, 0, 7'h07, 2, 67});
    d0 = ndone;
    bus.note_on_i = 1'b1; bus.note_off_i = 1'b1; bus.note_i = 7'd67;
    @(negedge clk); #1;
    bus.note_off_i = 1'b0;
    wait_done(d0 + 1);
    wait_ready();
    if (sb.size() > 0) sb[0].acc = cyc;
    @(negedge clk); #1;
    bus.note_on_i = 1'b0;
    wait_done(d0 + 2);

    for (int i = 6; i < 13; i++) send(vt[i]);

    // reset in the middle of a note_on scan: aborted, no pulse
    nrst = 1'b0;
    @(negedge clk); #1;
    nrst = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      v = '{1, 0, 7'(10 + i), 1, i, i + 2, 7'((1 << (i + 1)) - 1), i, 10 + i};
      send(v);
    end
    wait_ready();
    d0 = ndone;
    bus.note_on_i = 1'b1; bus.note_i = 7'd13;
    @(negedge clk); #1;
    bus.note_on_i = 1'b0;
    @(negedge clk); #1;
    nrst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", ndone, d0);
    chk("abort_done_o", int'(bus.done_o), 0);
    chk("abort_mask", int'(bus.voice_mask_o), 0);
    chk("abort_count", int'(bus.count_o), 0);
    chk("abort_ready", int'(bus.ready_o), 1);
    nrst = 1'b1;
    @(negedge clk); #1;
    v = '{1, 0, 20, 1, 0, 2, 7'h01, 0, 20};
    send(v);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
